// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller and its opcode classifier:
// opcodes, FSM states, instruction classes and datapath select codes.
package ctrl_pkg;

   localparam logic [6:0] OP_HALT = 7'b0000000;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_U    = 7'b0110111;
   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;

   typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

   typedef enum logic [3:0] {
      CL_R, CL_I, CL_U, CL_LW, CL_SW, CL_BR, CL_JAL, CL_JALR, CL_HALT, CL_ILL
   } iclass_t;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_BR    = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;
   localparam logic [1:0] ALU_LUI   = 2'b11;

   localparam logic [1:0] PC_PLUS4  = 2'b00;
   localparam logic [1:0] PC_TGT    = 2'b01;
   localparam logic [1:0] PC_JALR   = 2'b10;

   localparam logic [1:0] WB_ALU    = 2'b00;
   localparam logic [1:0] WB_MEM    = 2'b01;
   localparam logic [1:0] WB_PC4    = 2'b10;

   function automatic logic alu_imm(input iclass_t c);
      return (c == CL_I) || (c == CL_U) || (c == CL_LW) || (c == CL_SW);
   endfunction

   function automatic logic [1:0] alu_op_of(input iclass_t c);
      case (c)
         CL_R, CL_I: return ALU_FUNCT;
         CL_U:       return ALU_LUI;
         CL_BR:      return ALU_BR;
         default:    return ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/ctrl_opdec.sv
// Combinational opcode classifier, shared with the pipelined decoder.
// CTRL_JUMP_EN makes JAL/JALR legal; otherwise they classify as illegal.
module ctrl_opdec
   import ctrl_pkg::*;
(
   input  logic [6:0] opcode,
   output iclass_t    iclass,
   output logic       legal
);

   always_comb begin
      iclass = CL_ILL;
      case (opcode)
         OP_HALT: iclass = CL_HALT;
         OP_R:    iclass = CL_R;
         OP_I:    iclass = CL_I;
         OP_U:    iclass = CL_U;
         OP_LW:   iclass = CL_LW;
         OP_SW:   iclass = CL_SW;
         OP_BR:   iclass = CL_BR;
`ifdef CTRL_JUMP_EN
         OP_JAL:  iclass = CL_JAL;
         OP_JALR: iclass = CL_JALR;
`endif
         default: iclass = CL_ILL;
      endcase
      legal = (iclass != CL_ILL);
   end

endmodule

// File: rtl/multicycle_controller.sv
// RV32 multicycle sequencer: FETCH/DECODE/EXEC/MEM/WB with memory timeout,
// sticky halt and retired counter. CTRL_JUMP_EN adds JAL/JALR sequencing.
module multicycle_controller
   import ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [6:0]       opcode,
   input  logic             mem_ready,
   input  logic             branch_cond,
   output logic             mem_req,
   output logic             mem_we,
   output logic             ir_write,
   output logic             pc_write,
   output logic [1:0]       pc_src,
   output logic             alu_src,
   output logic [1:0]       alu_op,
   output logic [1:0]       mem_to_reg,
   output logic             reg_write,
   output logic             flag_halt,
   output logic             illegal,
   output logic             bus_err,
   output logic [CNT_W-1:0] retired_cnt
);

   localparam int TO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

   state_t           state, state_nx;
   iclass_t          cls_q, dec_cls;
   logic             dec_legal;
   logic [TO_W-1:0]  to_cnt;
   logic             to_limit, to_hit, retire;
   logic             ill_q, berr_q;
   logic [CNT_W-1:0] cnt_q;

   ctrl_opdec u_opdec (
      .opcode (opcode),
      .iclass (dec_cls),
      .legal  (dec_legal)
   );

   // to_cnt holds the number of unanswered request cycles already spent
   generate
      if (MEM_TIMEOUT > 0) begin : g_to
         assign to_limit = (to_cnt == TO_W'(MEM_TIMEOUT - 1));
      end else begin : g_no_to
         assign to_limit = 1'b0;
      end
   endgenerate

   always_comb begin
      state_nx   = state;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = PC_PLUS4;
      alu_src    = 1'b0;
      alu_op     = ALU_ADD;
      mem_to_reg = WB_ALU;
      reg_write  = 1'b0;
      to_hit     = 1'b0;
      // ALU controls stay stable while the result is consumed in MEM/WB
      if ((state == EXEC) || (state == MEM) || (state == WB)) begin
         alu_src = alu_imm(cls_q);
         alu_op  = alu_op_of(cls_q);
      end
      case (state)
         FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_nx = DECODE;
            end else if (to_limit) begin
               to_hit   = 1'b1;
               state_nx = HALT;
            end
         end
         DECODE: begin
            if (!dec_legal || (dec_cls == CL_HALT)) state_nx = HALT;
            else                                    state_nx = EXEC;
         end
         EXEC: begin
            case (cls_q)
               CL_LW, CL_SW: state_nx = MEM;
               CL_BR: begin
                  pc_write = branch_cond;
                  pc_src   = PC_TGT;
                  state_nx = FETCH;
               end
`ifdef CTRL_JUMP_EN
               CL_JAL, CL_JALR: begin
                  pc_write = 1'b1;
                  pc_src   = (cls_q == CL_JALR) ? PC_JALR : PC_TGT;
                  state_nx = WB;
               end
`endif
               default: state_nx = WB;
            endcase
         end
         MEM: begin
            mem_req = 1'b1;
            mem_we  = (cls_q == CL_SW);
            if (mem_ready) begin
               state_nx = (cls_q == CL_SW) ? FETCH : WB;
            end else if (to_limit) begin
               to_hit   = 1'b1;
               state_nx = HALT;
            end
         end
         WB: begin
            reg_write = 1'b1;
            if (cls_q == CL_LW) mem_to_reg = WB_MEM;
`ifdef CTRL_JUMP_EN
            if ((cls_q == CL_JAL) || (cls_q == CL_JALR)) mem_to_reg = WB_PC4;
`endif
            state_nx = FETCH;
         end
         HALT:    state_nx = HALT;
         default: state_nx = FETCH;
      endcase
      // reset forces every strobe low immediately, not at the next edge
      if (!rst_n) begin
         mem_req    = 1'b0;
         mem_we     = 1'b0;
         ir_write   = 1'b0;
         pc_write   = 1'b0;
         pc_src     = PC_PLUS4;
         alu_src    = 1'b0;
         alu_op     = ALU_ADD;
         mem_to_reg = WB_ALU;
         reg_write  = 1'b0;
         to_hit     = 1'b0;
      end
   end

   assign retire = (state_nx == FETCH) &&
                   ((state == EXEC) || (state == MEM) || (state == WB));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= FETCH;
         cls_q  <= CL_ILL;
         to_cnt <= '0;
         ill_q  <= 1'b0;
         berr_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         state <= state_nx;
         if (state == DECODE) cls_q <= dec_cls;
         if (state_nx != state)            to_cnt <= '0;
         else if (mem_req && !mem_ready)   to_cnt <= to_cnt + 1'b1;
         if ((state == DECODE) && !dec_legal) ill_q <= 1'b1;
         if (to_hit) berr_q <= 1'b1;
         if (retire && (cnt_q != {CNT_W{1'b1}})) cnt_q <= cnt_q + 1'b1;
      end
   end

   assign flag_halt   = (state == HALT);
   assign illegal     = ill_q;
   assign bus_err     = berr_q;
   assign retired_cnt = cnt_q;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Parametrised successor to the single-cycle main decoder.
- Sequences each RV32 instruction through FETCH/DECODE/EXEC/MEM/WB and drives datapath enables per state.
- Handshakes with a variable-latency memory, times out on a hung bus, has a sticky halt, and counts retired instructions.
- Sits between the instruction register/memory port and the multicycle datapath.

Parameters:
- MEM_TIMEOUT, 16: max cycles waiting on mem_ready per access; 0 disables the timeout.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- opcode  in  7  IR[6:0]; valid from DECODE onward.
- mem_ready  in  1  memory completes the current access this cycle.
- branch_cond  in  1  ALU compare result for the branch.
- mem_req  out  1  memory access request; held until mem_ready.
- mem_we  out  1  write strobe, qualified by mem_req.
- ir_write  out  1  load IR.
- pc_write  out  1  update PC.
- pc_src  out  2  00 PC+4, 01 branch/JAL target, 10 JALR target.
- alu_src  out  1  0 rs2, 1 immediate.
- alu_op  out  2  00 add (LW/SW), 01 branch compare, 10 R/I funct decode, 11 LUI pass-through.
- mem_to_reg  out  2  00 ALU, 01 memory, 10 PC+4.
- reg_write  out  1  register file write enable.
- flag_halt  out  1  sticky halt.
- illegal  out  1  sticky; halt caused by an unknown opcode.
- bus_err  out  1  sticky; halt caused by a timeout.
- retired_cnt  out  CNT_W  completed instructions.

Behaviour:
- Reset (async, rst_n=0):
  - state=FETCH, all outputs 0, retired_cnt=0, timeout counter 0.
  - mem_req drops combinationally with reset.
- Outputs are registered state plus Moore/Mealy decode; only mem_ready and branch_cond enter combinationally.
- FETCH:
  - mem_req=1, mem_we=0.
  - On mem_ready: ir_write=1, pc_write=1, pc_src=00, go to DECODE.
  - Otherwise stay.
- DECODE (1 cycle): classify opcode.
  - 0000000: HALT, illegal=0.
  - R 0110011, I 0010011, U 0110111, LW 0000011, SW 0100011, BR 1100011: go to EXEC.
  - Anything else: HALT with illegal=1.
- EXEC:
  - alu_src=1 for I/U/LW/SW, 0 otherwise.
  - alu_op per type.
  - R/I/U: go to WB.
  - LW/SW: go to MEM.
  - BR: pc_write=branch_cond, pc_src=01, go to FETCH (instruction retires).
- MEM:
  - mem_req=1, mem_we=(SW).
  - On mem_ready: LW goes to WB; SW goes to FETCH (retires).
- WB: reg_write=1 for exactly one cycle; mem_to_reg=01 for LW, 00 otherwise; go to FETCH (retires).
- Retirement: retired_cnt += 1 on every transition into FETCH from EXEC, MEM or WB. Saturates at all-ones with no wrap.
- Timeout:
  - Counter clears on entry to FETCH/MEM and counts each cycle mem_req=1 && !mem_ready.
  - When it reaches MEM_TIMEOUT: go to HALT, bus_err=1.
  - mem_ready in the same cycle as the limit wins; the access completes.
- HALT:
  - All enables 0, flag_halt=1.
  - Only rst_n exits; all inputs are ignored.
- Minimum latency with zero-wait memory: R/I/U 4 cycles, LW 5, SW 4, BR 3.

Optional Feature:
- Macro: CTRL_JUMP_EN.
- Defined:
  - JAL 1101111 and JALR 1100111 are legal.
  - EXEC: pc_write=1, pc_src=01 (JAL) or 10 (JALR), go to WB.
  - WB: mem_to_reg=10, reg_write=1.
- Undefined: both opcodes are illegal (HALT, illegal=1). Encodings 10 of pc_src and mem_to_reg are never driven.

Decomposition:
- Package ctrl_pkg holds:
  - opcode localparams;
  - state enum (FETCH, DECODE, EXEC, MEM, WB, HALT);
  - alu_op, pc_src and mem_to_reg encodings;
  - instruction-class enum.
- One sub-module, ctrl_opdec: combinational opcode to class plus legal flag. It is shared with the future pipelined decoder.

Test Plan:
- Reset, IR=addi (0010011), mem_ready=1 each request -> ir_write cycle 1, reg_write in cycle 4 with alu_src=1, alu_op=10, mem_to_reg=00; retired_cnt=1.
- LW with mem_ready delayed 3 cycles in MEM -> mem_req high 4 cycles, mem_we=0, then WB with mem_to_reg=01; total 8 cycles.
- BEQ with branch_cond=1 -> EXEC pc_write=1, pc_src=01, reg_write never set. Repeat with branch_cond=0 -> pc_write=0 in EXEC; retired_cnt increments both times.
- Opcode 0000000 -> flag_halt=1 after DECODE, illegal=0, outputs stay 0 over 20 cycles of random inputs. Opcode 1111111 -> illegal=1.
- MEM_TIMEOUT=8, mem_ready held 0 in FETCH -> bus_err=1 and flag_halt=1 after 8 request cycles. Variant with mem_ready=1 on the 8th cycle -> normal fetch, no error.
- rst_n pulled low mid-MEM on an SW -> mem_req and mem_we drop without waiting for clk; after release, FETCH with retired_cnt=0.
